nfifo2mem: RTL and testbench
============================

Name: nfifo2mem

Overview:
- Write-side counterpart of mem2nfifo. FLOWS independent FIFO-style write channels share one DATA_IN bus and fill per-flow circular blocks in a single shared memory.
- The read side is a random-access memory interface. The consumer addresses a word by flow and offset from that flow's head, then explicitly releases words to free space.
- Sits between per-flow producers (e.g. DMA/RX buffers) and a memory-oriented consumer.

Parameters:
- DATA_WIDTH, 64: width of one data word.
- FLOWS, 4: number of flows; power of 2, at least 2.
- BLOCK_SIZE, 512: words per flow block; power of 2.
- LUT_MEMORY, 0: 1 = distributed RAM, 0 = block RAM. Latency is identical in both cases.
- GLOB_STATE, 0: 1 = STATUS carries live occupancy; 0 = STATUS tied to zero.

Ports:
- CLK  in  1  clock
- RESET  in  1  synchronous reset, active-high
- DATA_IN  in  DATA_WIDTH  write data, shared by all flows
- WRITE  in  FLOWS  per-flow write strobe; one-hot or zero
- FULL  out  FLOWS  per-flow block full
- BLOCK_ADDR  in  log2(FLOWS)  flow selected for read
- RD_ADDR  in  log2(BLOCK_SIZE)  read offset from the flow's head
- READ  in  1  read request
- DATA_OUT  out  DATA_WIDTH  read data
- DATA_VLD  out  1  DATA_OUT valid
- REL_LEN  in  log2(BLOCK_SIZE)+1  number of words to release
- REL_LEN_DV  in  FLOWS  per-flow release strobe
- EMPTY  out  FLOWS  per-flow block empty
- STATUS  out  FLOWS*(log2(BLOCK_SIZE)+1)  per-flow occupancy
- OVERFLOW  out  FLOWS  sticky overflow flag; see Optional Feature

Behaviour:
- Per-flow state: wr_ptr, rd_ptr (log2(BLOCK_SIZE) bits each, wrap modulo BLOCK_SIZE) and cnt (0..BLOCK_SIZE).
- Reset values: pointers and cnt = 0, FULL = 0, EMPTY = all ones, DATA_VLD = 0, DATA_OUT = 0, STATUS = 0, OVERFLOW = 0.
- Write:
  - WRITE[f]=1 with FULL[f]=0 stores DATA_IN at address f*BLOCK_SIZE + wr_ptr[f], then wr_ptr[f]++ and cnt[f]++.
  - A write while FULL[f]=1 is dropped; no state changes.
  - If more than one WRITE bit is set (protocol violation), only the lowest index is accepted and the others are dropped.
- FULL, EMPTY and STATUS are registered from cnt and update the cycle after the event.
  - FULL[f] = (cnt==BLOCK_SIZE).
  - EMPTY[f] = (cnt==0).
  - A word written in cycle N is readable by a READ issued in cycle N+1 or later.
- Read:
  - READ in cycle N reads address BLOCK_ADDR*BLOCK_SIZE + ((rd_ptr[BLOCK_ADDR] + RD_ADDR) mod BLOCK_SIZE).
  - DATA_OUT is presented with DATA_VLD=1 in cycle N+2 (memory register plus output register). Fully pipelined: one read per cycle, no backpressure.
  - DATA_VLD=0 in cycles with no read result; DATA_OUT holds its last value.
  - Reading an offset at or beyond cnt returns stale memory contents with no error.
  - The head used for the address is rd_ptr sampled in cycle N.
- Release:
  - REL_LEN_DV[f]=1 advances rd_ptr[f] += REL_LEN and decrements cnt[f] by REL_LEN.
  - If REL_LEN exceeds cnt[f], the release is clamped to cnt[f].
  - Multiple REL_LEN_DV bits in one cycle apply the same REL_LEN to each flagged flow.
  - REL_LEN=0 is a no-op.
- Accepted write and release to the same flow in the same cycle: cnt_next = cnt + 1 - min(REL_LEN, cnt).
  - The clamp uses the pre-write cnt, so a just-written word cannot be released in the same cycle.
- RESET mid-operation:
  - Pointers and counts clear on the next edge. Memory contents are not cleared.
  - In-flight read results are discarded: DATA_VLD=0 for the two cycles following reset.

Optional Feature:
- Macro: NFIFO2MEM_OVERFLOW_FLAG_EN.
- Defined: OVERFLOW[f] is set the cycle after a write to flow f is dropped because the block is full. It stays set until RESET or an accepted release (REL_LEN_DV[f]=1 with REL_LEN>0) on flow f.
- Not defined: OVERFLOW is tied to 0 and no detection logic is built.

Decomposition:
- Package nfifo2mem_pkg holds:
  - ADDR_W = log2(BLOCK_SIZE) and FLOW_W = log2(FLOWS);
  - CNT_W = ADDR_W+1;
  - a typedef for the per-flow pointer/count record;
  - the default parameter constants.
- Sub-module nfifo2mem_ptr_ctrl is instantiated once per flow. It owns wr_ptr, rd_ptr, cnt, FULL, EMPTY, the clamped release and the overflow flag.
- The top level holds the write-strobe priority select, the shared memory (LUT_MEMORY choice) and the read pipeline.

Test Plan:
- Reset, then write 3 words (0xA0, 0xA1, 0xA2) to flow 1 → STATUS[1]=3 and EMPTY[1]=0 one cycle after the last write. READ with BLOCK_ADDR=1 and RD_ADDR=0, 1, 2 on consecutive cycles → DATA_OUT = 0xA0, 0xA1, 0xA2 two cycles after each request, DATA_VLD=1.
- Write 512 words to flow 0 → FULL[0]=1. A 513th write is dropped: STATUS[0] stays 512 and OVERFLOW[0]=1 with the macro defined.
- Release REL_LEN=2 on flow 1 after test 1, then READ RD_ADDR=0 → 0xA2 and STATUS[1]=1. Releasing REL_LEN=5 clamps → STATUS[1]=0, EMPTY[1]=1.
- Wrap-around: on flow 2, write 512, release 500, write 10 → STATUS=22. READ RD_ADDR=12 → returns the 1st word of the second batch (physical slot 0).
- Simultaneous write and release REL_LEN=1 on flow 3 with cnt=4 → cnt stays 4. WRITE=4'b0110 → only flow 1 is incremented.
- Assert RESET while reads are in flight → DATA_VLD=0 for the next 2 cycles, all EMPTY=1, STATUS=0.

Source files
------------

// File: rtl/nfifo2mem_pkg.sv
// rtl/nfifo2mem_pkg.sv - shared widths, default parameters and per-flow record type for nfifo2mem
package nfifo2mem_pkg;

    localparam int DEF_DATA_WIDTH = 64;
    localparam int DEF_FLOWS      = 4;
    localparam int DEF_BLOCK_SIZE = 512;
    localparam int DEF_LUT_MEMORY = 0;
    localparam int DEF_GLOB_STATE = 0;

    localparam int ADDR_W = $clog2(DEF_BLOCK_SIZE);
    localparam int FLOW_W = $clog2(DEF_FLOWS);
    localparam int CNT_W  = ADDR_W + 1;

    // Pointer/count record of one flow at the default geometry
    typedef struct packed {
        logic [ADDR_W-1:0] wr_ptr;
        logic [ADDR_W-1:0] rd_ptr;
        logic [CNT_W-1:0]  cnt;
    } flow_state_t;

endpackage

// File: rtl/nfifo2mem_ptr_ctrl.sv
// rtl/nfifo2mem_ptr_ctrl.sv - per-flow write/read pointers, occupancy, full/empty and clamped release
// Optional sticky overflow flag built only when NFIFO2MEM_OVERFLOW_FLAG_EN is defined.
module nfifo2mem_ptr_ctrl
    import nfifo2mem_pkg::*;
#(
    parameter int  BLOCK_SIZE = DEF_BLOCK_SIZE,
    localparam int AW         = $clog2(BLOCK_SIZE),
    localparam int CW         = AW + 1
) (
    input  logic          i_clk,
    input  logic          i_reset,
    input  logic          i_wr,
    input  logic          i_rel_dv,
    input  logic [CW-1:0] i_rel_len,
    output logic          o_wr_acc,
    output logic [AW-1:0] o_wr_ptr,
    output logic [AW-1:0] o_rd_ptr,
    output logic [CW-1:0] o_cnt,
    output logic          o_full,
    output logic          o_empty,
    output logic          o_overflow
);

    logic [AW-1:0] r_wr_ptr;
    logic [AW-1:0] r_rd_ptr;
    logic [CW-1:0] r_cnt;
    logic          r_full;
    logic          r_empty;
    logic          w_wr_acc;
    logic [CW-1:0] w_rel_amt;
    logic [CW-1:0] w_cnt_nxt;

    assign w_wr_acc = i_wr && !r_full;

    // Clamp uses the pre-write count so a word written this cycle is never released
    always_comb begin
        w_rel_amt = '0;
        if (i_rel_dv) begin
            w_rel_amt = (i_rel_len > r_cnt) ? r_cnt : i_rel_len;
        end
        w_cnt_nxt = r_cnt + CW'(w_wr_acc) - w_rel_amt;
    end

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_cnt    <= '0;
            r_full   <= 1'b0;
            r_empty  <= 1'b1;
        end else begin
            if (w_wr_acc) begin
                r_wr_ptr <= r_wr_ptr + AW'(1);
            end
            r_rd_ptr <= r_rd_ptr + w_rel_amt[AW-1:0];
            r_cnt    <= w_cnt_nxt;
            r_full   <= (w_cnt_nxt == CW'(BLOCK_SIZE));
            r_empty  <= (w_cnt_nxt == '0);
        end
    end

`ifdef NFIFO2MEM_OVERFLOW_FLAG_EN
    logic r_overflow;

    // A drop in the same cycle as a release wins: the lost word is still reported
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_overflow <= 1'b0;
        end else if (i_wr && r_full) begin
            r_overflow <= 1'b1;
        end else if (i_rel_dv && (i_rel_len != '0)) begin
            r_overflow <= 1'b0;
        end
    end

    assign o_overflow = r_overflow;
`else
    assign o_overflow = 1'b0;
`endif

    assign o_wr_acc = w_wr_acc;
    assign o_wr_ptr = r_wr_ptr;
    assign o_rd_ptr = r_rd_ptr;
    assign o_cnt    = r_cnt;
    assign o_full   = r_full;
    assign o_empty  = r_empty;

endmodule

// File: rtl/nfifo2mem.sv
// rtl/nfifo2mem.sv - FIFO-style per-flow writers into one shared memory, random-access read with release
// Sticky per-flow OVERFLOW flags are built only when NFIFO2MEM_OVERFLOW_FLAG_EN is defined.
module nfifo2mem
    import nfifo2mem_pkg::*;
#(
    parameter int  DATA_WIDTH = DEF_DATA_WIDTH,
    parameter int  FLOWS      = DEF_FLOWS,
    parameter int  BLOCK_SIZE = DEF_BLOCK_SIZE,
    parameter int  LUT_MEMORY = DEF_LUT_MEMORY,
    parameter int  GLOB_STATE = DEF_GLOB_STATE,
    localparam int AW         = $clog2(BLOCK_SIZE),
    localparam int FW         = $clog2(FLOWS),
    localparam int CW         = AW + 1
) (
    input  logic                  i_clk,
    input  logic                  i_reset,
    input  logic [DATA_WIDTH-1:0] i_data_in,
    input  logic [FLOWS-1:0]      i_write,
    output logic [FLOWS-1:0]      o_full,
    input  logic [FW-1:0]         i_block_addr,
    input  logic [AW-1:0]         i_rd_addr,
    input  logic                  i_read,
    output logic [DATA_WIDTH-1:0] o_data_out,
    output logic                  o_data_vld,
    input  logic [CW-1:0]         i_rel_len,
    input  logic [FLOWS-1:0]      i_rel_len_dv,
    output logic [FLOWS-1:0]      o_empty,
    output logic [FLOWS*CW-1:0]   o_status,
    output logic [FLOWS-1:0]      o_overflow
);

    localparam int DEPTH = FLOWS * BLOCK_SIZE;

    logic [FLOWS-1:0]      w_wr_sel;
    logic [FLOWS-1:0]      w_wr_acc;
    logic [FW-1:0]         w_wr_flow;
    logic [AW-1:0]         w_wr_ptr [FLOWS];
    logic [AW-1:0]         w_rd_ptr [FLOWS];
    logic [CW-1:0]         w_cnt    [FLOWS];
    logic [FW+AW-1:0]      w_wr_addr;
    logic [FW+AW-1:0]      w_rd_addr;
    logic [AW-1:0]         w_rd_off;
    logic [DATA_WIDTH-1:0] r_mem_q;
    logic                  r_rd_vld;
    logic                  r_data_vld;
    logic [DATA_WIDTH-1:0] r_data_out;

    // Isolate the lowest set strobe; higher ones are protocol violations and dropped
    assign w_wr_sel = i_write & (~i_write + FLOWS'(1));

    always_comb begin
        w_wr_flow = '0;
        for (int f = FLOWS - 1; f >= 0; f--) begin
            if (i_write[f]) begin
                w_wr_flow = FW'(f);
            end
        end
    end

    generate
        for (genvar f = 0; f < FLOWS; f++) begin : g_flow
            nfifo2mem_ptr_ctrl #(
                .BLOCK_SIZE (BLOCK_SIZE)
            ) u_ptr_ctrl (
                .i_clk      (i_clk),
                .i_reset    (i_reset),
                .i_wr       (w_wr_sel[f]),
                .i_rel_dv   (i_rel_len_dv[f]),
                .i_rel_len  (i_rel_len),
                .o_wr_acc   (w_wr_acc[f]),
                .o_wr_ptr   (w_wr_ptr[f]),
                .o_rd_ptr   (w_rd_ptr[f]),
                .o_cnt      (w_cnt[f]),
                .o_full     (o_full[f]),
                .o_empty    (o_empty[f]),
                .o_overflow (o_overflow[f])
            );

            if (GLOB_STATE != 0) begin : g_status
                assign o_status[f*CW +: CW] = w_cnt[f];
            end else begin : g_no_status
                assign o_status[f*CW +: CW] = '0;
            end
        end
    endgenerate

    assign w_wr_addr = {w_wr_flow, w_wr_ptr[w_wr_flow]};
    assign w_rd_off  = w_rd_ptr[i_block_addr] + i_rd_addr;
    assign w_rd_addr = {i_block_addr, w_rd_off};

    // Both memory styles register the read word once, so read latency does not depend on LUT_MEMORY
    generate
        if (LUT_MEMORY != 0) begin : g_lut_mem
            (* ram_style = "distributed" *) logic [DATA_WIDTH-1:0] r_mem [DEPTH];
            logic [DATA_WIDTH-1:0] w_lut_q;

            always_ff @(posedge i_clk) begin
                if (|w_wr_acc) begin
                    r_mem[w_wr_addr] <= i_data_in;
                end
            end

            assign w_lut_q = r_mem[w_rd_addr];

            always_ff @(posedge i_clk) begin
                r_mem_q <= w_lut_q;
            end
        end else begin : g_block_mem
            (* ram_style = "block" *) logic [DATA_WIDTH-1:0] r_mem [DEPTH];

            always_ff @(posedge i_clk) begin
                if (|w_wr_acc) begin
                    r_mem[w_wr_addr] <= i_data_in;
                end
                r_mem_q <= r_mem[w_rd_addr];
            end
        end
    endgenerate

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_rd_vld   <= 1'b0;
            r_data_vld <= 1'b0;
            r_data_out <= '0;
        end else begin
            r_rd_vld   <= i_read;
            r_data_vld <= r_rd_vld;
            if (r_rd_vld) begin
                r_data_out <= r_mem_q;
            end
        end
    end

    assign o_data_out = r_data_out;
    assign o_data_vld = r_data_vld;

endmodule

// File: tb/tb_nfifo2mem.sv
// tb/tb_nfifo2mem.sv - randomized self-checking bench for nfifo2mem against a behavioural per-flow model
module tb_nfifo2mem;

    localparam int DW = 64;
    localparam int FL = 4;
    localparam int BS = 512;
    localparam int AW = 9;
    localparam int FW = 2;
    localparam int CW = 10;

    logic            clk;
    logic            i_reset;
    logic [DW-1:0]   i_data_in;
    logic [FL-1:0]   i_write;
    logic [FL-1:0]   o_full;
    logic [FW-1:0]   i_block_addr;
    logic [AW-1:0]   i_rd_addr;
    logic            i_read;
    logic [DW-1:0]   o_data_out;
    logic            o_data_vld;
    logic [CW-1:0]   i_rel_len;
    logic [FL-1:0]   i_rel_len_dv;
    logic [FL-1:0]   o_empty;
    logic [FL*CW-1:0] o_status;
    logic [FL-1:0]   o_overflow;

    int total = 0;
    int bad   = 0;

    // Model: per-flow circular block with head index and occupancy
    int            m_cnt  [FL];
    int            m_head [FL];
    bit            m_ovf  [FL];
    logic [DW-1:0] m_mem  [FL][BS];
    bit            s1_vld;
    logic [DW-1:0] s1_dat;
    bit            e_vld;
    logic [DW-1:0] e_dout;

    nfifo2mem #(
        .DATA_WIDTH (DW),
        .FLOWS      (FL),
        .BLOCK_SIZE (BS),
        .LUT_MEMORY (0),
        .GLOB_STATE (1)
    ) dut (
        .i_clk        (clk),
        .i_reset      (i_reset),
        .i_data_in    (i_data_in),
        .i_write      (i_write),
        .o_full       (o_full),
        .i_block_addr (i_block_addr),
        .i_rd_addr    (i_rd_addr),
        .i_read       (i_read),
        .o_data_out   (o_data_out),
        .o_data_vld   (o_data_vld),
        .i_rel_len    (i_rel_len),
        .i_rel_len_dv (i_rel_len_dv),
        .o_empty      (o_empty),
        .o_status     (o_status),
        .o_overflow   (o_overflow)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    function automatic logic [FL*CW-1:0] exp_status();
        logic [FL*CW-1:0] v;
        for (int f = 0; f < FL; f++) v[f*CW +: CW] = CW'(m_cnt[f]);
        return v;
    endfunction

    function automatic logic [FL-1:0] exp_full();
        logic [FL-1:0] v;
        for (int f = 0; f < FL; f++) v[f] = (m_cnt[f] == BS);
        return v;
    endfunction

    function automatic logic [FL-1:0] exp_empty();
        logic [FL-1:0] v;
        for (int f = 0; f < FL; f++) v[f] = (m_cnt[f] == 0);
        return v;
    endfunction

    function automatic logic [FL-1:0] exp_ovf();
        logic [FL-1:0] v;
        for (int f = 0; f < FL; f++) v[f] = m_ovf[f];
        return v;
    endfunction

    // Apply the current inputs to the model, clock once, then clear strobes
    task automatic step();
        int wf;
        int amt;
        bit wacc;
        logic [DW-1:0] rdat;
        rdat = '0;
        if (i_read) rdat = m_mem[i_block_addr][(m_head[i_block_addr] + int'(i_rd_addr)) % BS];
        wf = -1;
        wacc = 0;
        for (int f = FL - 1; f >= 0; f--) if (i_write[f]) wf = f;
        if (wf >= 0 && m_cnt[wf] < BS) begin
            m_mem[wf][(m_head[wf] + m_cnt[wf]) % BS] = i_data_in;
            wacc = 1;
        end
        for (int f = 0; f < FL; f++) begin
            amt = 0;
            if (i_rel_len_dv[f]) amt = (int'(i_rel_len) > m_cnt[f]) ? m_cnt[f] : int'(i_rel_len);
            if (i_rel_len_dv[f] && i_rel_len != 0) m_ovf[f] = 0;
`ifdef NFIFO2MEM_OVERFLOW_FLAG_EN
            if (f == wf && !wacc) m_ovf[f] = 1;
`endif
            m_head[f] = (m_head[f] + amt) % BS;
            m_cnt[f]  = m_cnt[f] + ((f == wf && wacc) ? 1 : 0) - amt;
        end
        if (i_reset) begin
            for (int f = 0; f < FL; f++) begin
                m_cnt[f] = 0; m_head[f] = 0; m_ovf[f] = 0;
            end
            s1_vld = 0; e_vld = 0; e_dout = '0;
        end else begin
            e_vld = s1_vld;
            if (s1_vld) e_dout = s1_dat;
            s1_vld = i_read;
            s1_dat = rdat;
        end
        @(posedge clk);
        #1;
        i_write = '0;
        i_read = 1'b0;
        i_rel_len_dv = '0;
    endtask

    task automatic test_reset();
        i_reset = 1'b1;
        step();
        step();
        i_reset = 1'b0;
        total++; if (o_empty !== 4'hF) begin bad++; $display("FAIL reset_empty: got %0h want f", o_empty); end
        total++; if (o_full !== 4'h0) begin bad++; $display("FAIL reset_full: got %0h want 0", o_full); end
        total++; if (o_status !== '0) begin bad++; $display("FAIL reset_status: got %0h want 0", o_status); end
        total++; if (o_data_vld !== 1'b0) begin bad++; $display("FAIL reset_vld: got %0b want 0", o_data_vld); end
        total++; if (o_data_out !== '0) begin bad++; $display("FAIL reset_dout: got %0h want 0", o_data_out); end
        total++; if (o_overflow !== 4'h0) begin bad++; $display("FAIL reset_ovf: got %0h want 0", o_overflow); end
    endtask

    task automatic test_write_read();
        for (int k = 0; k < 3; k++) begin
            i_write = 4'b0010;
            i_data_in = 64'hA0 + 64'(k);
            step();
        end
        total++; if (o_status[CW +: CW] !== 10'd3) begin bad++; $display("FAIL wr_status1: got %0d want 3", o_status[CW +: CW]); end
        total++; if (o_empty[1] !== 1'b0) begin bad++; $display("FAIL wr_empty1: got %0b want 0", o_empty[1]); end
        for (int k = 0; k < 5; k++) begin
            if (k < 3) begin
                i_block_addr = 2'd1;
                i_rd_addr = AW'(k);
                i_read = 1'b1;
            end
            step();
            total++;
            if (o_data_vld !== ((k >= 1) && (k <= 3))) begin
                bad++; $display("FAIL rd_vld k=%0d: got %0b", k, o_data_vld);
            end
            if (k >= 1 && k <= 3) begin
                total++;
                if (o_data_out !== 64'hA0 + 64'(k - 1)) begin
                    bad++; $display("FAIL rd_data k=%0d: got %0h want %0h", k, o_data_out, 64'hA0 + 64'(k - 1));
                end
            end
        end
    endtask

    task automatic test_full();
        for (int k = 0; k < BS; k++) begin
            i_write = 4'b0001;
            i_data_in = {$urandom, $urandom};
            step();
        end
        total++; if (o_full[0] !== 1'b1) begin bad++; $display("FAIL full0: got %0b want 1", o_full[0]); end
        total++; if (o_status[0 +: CW] !== 10'd512) begin bad++; $display("FAIL full_status0: got %0d want 512", o_status[0 +: CW]); end
        i_write = 4'b0001;
        i_data_in = 64'hDEAD;
        step();
        total++; if (o_status[0 +: CW] !== 10'd512) begin bad++; $display("FAIL drop_status0: got %0d want 512", o_status[0 +: CW]); end
`ifdef NFIFO2MEM_OVERFLOW_FLAG_EN
        total++; if (o_overflow[0] !== 1'b1) begin bad++; $display("FAIL ovf0: got %0b want 1", o_overflow[0]); end
`else
        total++; if (o_overflow[0] !== 1'b0) begin bad++; $display("FAIL ovf0: got %0b want 0", o_overflow[0]); end
`endif
        for (int k = 0; k < 6; k++) begin
            if (k < 4) begin
                i_block_addr = 2'd0;
                i_rd_addr = (k == 0) ? AW'(BS - 1) : AW'($urandom_range(0, BS - 1));
                i_read = 1'b1;
            end
            step();
            total++;
            if (o_data_vld !== e_vld || o_data_out !== e_dout) begin
                bad++; $display("FAIL full_read k=%0d: got %0b/%0h want %0b/%0h", k, o_data_vld, o_data_out, e_vld, e_dout);
            end
        end
    endtask

    task automatic test_release();
        i_rel_len = 10'd2;
        i_rel_len_dv = 4'b0010;
        step();
        total++; if (o_status[CW +: CW] !== 10'd1) begin bad++; $display("FAIL rel_status1: got %0d want 1", o_status[CW +: CW]); end
        i_block_addr = 2'd1;
        i_rd_addr = '0;
        i_read = 1'b1;
        step();
        step();
        total++; if (o_data_vld !== 1'b1 || o_data_out !== 64'hA2) begin bad++; $display("FAIL rel_read: got %0b/%0h want 1/a2", o_data_vld, o_data_out); end
        i_rel_len = 10'd5;
        i_rel_len_dv = 4'b0010;
        step();
        total++; if (o_status[CW +: CW] !== 10'd0) begin bad++; $display("FAIL clamp_status1: got %0d want 0", o_status[CW +: CW]); end
        total++; if (o_empty[1] !== 1'b1) begin bad++; $display("FAIL clamp_empty1: got %0b want 1", o_empty[1]); end
    endtask

    task automatic test_wrap();
        for (int k = 0; k < BS; k++) begin
            i_write = 4'b0100;
            i_data_in = {$urandom, $urandom};
            step();
        end
        i_rel_len = 10'd500;
        i_rel_len_dv = 4'b0100;
        step();
        for (int k = 0; k < 10; k++) begin
            i_write = 4'b0100;
            i_data_in = 64'hB000 + 64'(k);
            step();
        end
        total++; if (o_status[2*CW +: CW] !== 10'd22) begin bad++; $display("FAIL wrap_status2: got %0d want 22", o_status[2*CW +: CW]); end
        i_block_addr = 2'd2;
        i_rd_addr = 9'd12;
        i_read = 1'b1;
        step();
        step();
        total++; if (o_data_vld !== 1'b1 || o_data_out !== 64'hB000) begin bad++; $display("FAIL wrap_read: got %0b/%0h want 1/b000", o_data_vld, o_data_out); end
    endtask

    task automatic test_simul();
        for (int k = 0; k < 4; k++) begin
            i_write = 4'b1000;
            i_data_in = {$urandom, $urandom};
            step();
        end
        i_write = 4'b1000;
        i_data_in = 64'hC0C0;
        i_rel_len = 10'd1;
        i_rel_len_dv = 4'b1000;
        step();
        total++; if (o_status[3*CW +: CW] !== 10'd4) begin bad++; $display("FAIL simul_status3: got %0d want 4", o_status[3*CW +: CW]); end
        i_write = 4'b0110;
        i_data_in = 64'hD1;
        step();
        total++; if (o_status[CW +: CW] !== 10'd1) begin bad++; $display("FAIL multihot_status1: got %0d want 1", o_status[CW +: CW]); end
        total++; if (o_status[2*CW +: CW] !== 10'd22) begin bad++; $display("FAIL multihot_status2: got %0d want 22", o_status[2*CW +: CW]); end
    endtask

    task automatic test_random();
        int b;
        int r;
        for (int cyc = 0; cyc < 1500; cyc++) begin
            r = $urandom_range(0, 9);
            if (r < 7) begin
                if ($urandom_range(0, 9) == 0) i_write = 4'($urandom);
                else i_write = 4'(1 << $urandom_range(0, FL - 1));
                i_data_in = {$urandom, $urandom};
            end
            if ($urandom_range(0, 99) < 15) begin
                i_rel_len_dv = 4'($urandom_range(1, 15));
                i_rel_len = CW'($urandom_range(0, 6));
            end
            b = $urandom_range(0, FL - 1);
            if (m_cnt[b] > 0 && $urandom_range(0, 9) < 6) begin
                i_block_addr = FW'(b);
                i_rd_addr = AW'($urandom_range(0, m_cnt[b] - 1));
                i_read = 1'b1;
            end
            step();
            total++; if (o_status !== exp_status()) begin bad++; $display("FAIL rand_status cyc=%0d: got %0h want %0h", cyc, o_status, exp_status()); end
            total++; if (o_full !== exp_full() || o_empty !== exp_empty()) begin bad++; $display("FAIL rand_flags cyc=%0d: got %0h/%0h want %0h/%0h", cyc, o_full, o_empty, exp_full(), exp_empty()); end
            total++; if (o_data_vld !== e_vld || o_data_out !== e_dout) begin bad++; $display("FAIL rand_read cyc=%0d: got %0b/%0h want %0b/%0h", cyc, o_data_vld, o_data_out, e_vld, e_dout); end
            total++; if (o_overflow !== exp_ovf()) begin bad++; $display("FAIL rand_ovf cyc=%0d: got %0h want %0h", cyc, o_overflow, exp_ovf()); end
        end
    endtask

    task automatic test_reset_inflight();
        int b;
        b = 0;
        for (int f = FL - 1; f >= 0; f--) if (m_cnt[f] < BS) b = f;
        i_write = 4'(1 << b);
        i_data_in = 64'hE0E0;
        step();
        i_block_addr = FW'(b);
        i_rd_addr = '0;
        i_read = 1'b1;
        step();
        i_block_addr = FW'(b);
        i_rd_addr = '0;
        i_read = 1'b1;
        i_reset = 1'b1;
        step();
        i_reset = 1'b0;
        total++; if (o_data_vld !== 1'b0) begin bad++; $display("FAIL rst_vld0: got %0b want 0", o_data_vld); end
        total++; if (o_empty !== 4'hF) begin bad++; $display("FAIL rst_empty: got %0h want f", o_empty); end
        total++; if (o_status !== '0) begin bad++; $display("FAIL rst_status: got %0h want 0", o_status); end
        step();
        total++; if (o_data_vld !== 1'b0) begin bad++; $display("FAIL rst_vld1: got %0b want 0", o_data_vld); end
        total++; if (o_data_out !== '0) begin bad++; $display("FAIL rst_dout: got %0h want 0", o_data_out); end
    endtask

    initial begin
        i_reset = 1'b1;
        i_data_in = '0;
        i_write = '0;
        i_block_addr = '0;
        i_rd_addr = '0;
        i_read = 1'b0;
        i_rel_len = '0;
        i_rel_len_dv = '0;
        for (int f = 0; f < FL; f++) begin
            m_cnt[f] = 0; m_head[f] = 0; m_ovf[f] = 0;
        end
        s1_vld = 0; s1_dat = '0; e_vld = 0; e_dout = '0;
        test_reset();
        test_write_read();
        test_full();
        test_release();
        test_wrap();
        test_simul();
        test_random();
        test_reset_inflight();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
